des_key_scheduler: RTL and testbench

Sequential DES key scheduler. It produces the 16 round subkeys one per handshake from a single 64-bit key, in forward order for encryption or reverse order for decryption. It holds only the 28-bit C/D halves and rotates them in place, replacing the flat 16-output subkey generator in the round pipeline. It feeds the iterative round datapath through a valid/ready interface.

---
 rtl/des_key_scheduler_if.sv | 30 +++
 rtl/des_key_scheduler.sv | 151 +++++++++++++++
 tb/tb_des_key_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_scheduler_if.sv
// Start/key control and the subkey valid/ready stream between the DES key
// scheduler and the iterative round datapath.
interface des_key_scheduler_if;
  localparam int unsigned KEY_W = 64;
  localparam int unsigned SK_W  = 48;
  localparam int unsigned IDX_W = 4;

  logic              start;
  logic              decrypt;
  logic [KEY_W-1:0]  key;
  logic              busy;
  logic              key_err;
  logic              subkey_valid;
  logic              subkey_ready;
  logic [SK_W-1:0]   subkey;
  logic [IDX_W-1:0]  round_idx;
  logic              done;

  // Requester / round datapath side
  modport master (
    output start, decrypt, key, subkey_ready,
    input  busy, key_err, subkey_valid, subkey, round_idx, done
  );

  // Key scheduler side
  modport slave (
    input  start, decrypt, key, subkey_ready,
    output busy, key_err, subkey_valid, subkey, round_idx, done
  );
endinterface

// File: rtl/des_key_scheduler.sv
// Sequential DES key scheduler: holds only the 28-bit C/D halves and rotates
// them in place, emitting one PC2 subkey per accepted handshake.
module des_key_scheduler #(
  parameter bit PARITY_CHECK = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  des_key_scheduler_if.slave   bus
);
  localparam int unsigned HALF_W = 28;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned SK_W   = 48;
  localparam int unsigned KEY_W  = 64;
  localparam int unsigned IDX_W  = 4;

  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [SK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [HALF_W-1:0]   c, c_nx, d, d_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic                mode, mode_nx;
  logic                key_err, key_err_nx;
  logic [CD_W-1:0]     cd_load;
  logic                parity_bad;
  logic                rot_two;

  // Bit n (1-based, MSB first) of a W-bit DES vector lives at index W-n.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[6'(55 - i)] = k[6'(64 - PC1_TAB[6'(i)])];
    return r;
  endfunction

  function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SK_W-1:0] r;
    r = '0;
    for (int j = 0; j < 48; j++)
      r[6'(47 - j)] = cd[6'(56 - PC2_TAB[6'(j)])];
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Shift table entry SH[n] (1-based) is 1 for rounds 1, 2, 9, 16 and 2 otherwise.
  function automatic logic sh_is_two(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  always_comb begin
    parity_bad = 1'b0;
    for (int b = 0; b < 8; b++)
      if (~^bus.key[6'(8 * b) +: 8]) parity_bad = 1'b1;
  end

  assign cd_load = pc1(bus.key);
  assign rot_two = sh_is_two(mode ? (5'd16 - 5'(idx)) : (5'(idx) + 5'd2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      c       <= '0;
      d       <= '0;
      idx     <= '0;
      mode    <= 1'b0;
      key_err <= 1'b0;
    end else begin
      state   <= state_nx;
      c       <= c_nx;
      d       <= d_nx;
      idx     <= idx_nx;
      mode    <= mode_nx;
      key_err <= key_err_nx;
    end
  end

  // Encrypt loads C1/D1 directly; decrypt loads C0/D0 (== C16/D16) and walks backwards.
  always_comb begin
    state_nx   = state;
    c_nx       = c;
    d_nx       = d;
    idx_nx     = idx;
    mode_nx    = mode;
    key_err_nx = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (PARITY_CHECK && parity_bad) begin
            key_err_nx = 1'b1;
          end else begin
            mode_nx  = bus.decrypt;
            idx_nx   = '0;
            c_nx     = bus.decrypt ? cd_load[55:28] : rotl(cd_load[55:28], 1'b0);
            d_nx     = bus.decrypt ? cd_load[27:0]  : rotl(cd_load[27:0],  1'b0);
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (bus.subkey_ready) begin
          if (idx == 4'd15) begin
            state_nx = DONE;
          end else begin
            idx_nx = idx + 4'd1;
            c_nx   = mode ? rotr(c, rot_two) : rotl(c, rot_two);
            d_nx   = mode ? rotr(d, rot_two) : rotl(d, rot_two);
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy         = (state != IDLE);
  assign bus.subkey_valid = (state == RUN);
  assign bus.done         = (state == DONE);
  assign bus.key_err      = key_err;
  assign bus.round_idx    = idx;
  assign bus.subkey       = pc2({c, d});

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: known-answer table, a whole-key
// reference model, randomized keys/backpressure and reset/ignore-start cases.
module tb_des_key_scheduler;
  localparam int MAX_CYC = 400;
  localparam logic [63:0] K0 = 64'h133457799BBCDFF1;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    bit          dec;
    logic [3:0]  idx;
    logic [47:0] exp;
  } kat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [47:0] got     [16];
  logic [47:0] got_enc [16];
  logic [47:0] got_dec [16];
  kat_t kat [6];

  des_key_scheduler_if bus();

  des_key_scheduler #(.PARITY_CHECK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Subkey Kn (n = 1..16) straight from the DES definition: PC1, cumulative rotation, PC2.
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int n);
    logic [63:0] t;
    logic [55:0] cd, tu;
    logic [27:0] c, dd;
    logic [47:0] r;
    int total;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      t  = k >> (64 - PC1[i]);
      cd = {cd[54:0], t[0]};
    end
    c = cd[55:28];
    dd = cd[27:0];
    total = 0;
    for (int i = 0; i < n; i++) total += SH[i];
    for (int i = 0; i < total; i++) begin
      c  = {c[26:0], c[27]};
      dd = {dd[26:0], dd[27]};
    end
    cd = {c, dd};
    r = '0;
    for (int j = 0; j < 48; j++) begin
      tu = cd >> (56 - PC2[j]);
      r  = {r[46:0], tu[0]};
    end
    return r;
  endfunction

  function automatic logic [63:0] fix_par(input logic [63:0] k);
    logic [63:0] r;
    logic [7:0]  byt;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      byt    = 8'(k >> (8 * b));
      byt[0] = ~(^byt[7:1]);
      r      = r | (64'(byt) << (8 * b));
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the DONE cycle.
  task automatic run_seq(input logic [63:0] k, input bit dec, input bit rnd_ready, input bit inject);
    int accepts;
    int cyc;
    bit rdy;
    logic [47:0] exp;
    bus.start   = 1'b1;
    bus.key     = k;
    bus.decrypt = dec;
    @(negedge clk);
    bus.start = 1'b0;
    check("first_valid", 64'(bus.subkey_valid), 64'd1);
    check("start_key_err", 64'(bus.key_err), 64'd0);
    accepts = 0;
    cyc = 0;
    while (accepts < 16 && cyc < MAX_CYC) begin
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.subkey_ready = rdy;
      bus.start = 1'(inject && cyc == 3);
      if (inject && cyc == 3) begin
        bus.key     = ~k;
        bus.decrypt = ~dec;
      end
      exp = model_subkey(k, dec ? 16 - accepts : accepts + 1);
      check("valid", 64'(bus.subkey_valid), 64'd1);
      check("subkey", 64'(bus.subkey), 64'(exp));
      check("round_idx", 64'(bus.round_idx), 64'(accepts));
      check("busy_run", 64'(bus.busy), 64'd1);
      if (bus.subkey_valid && rdy) begin
        got[4'(accepts)] = bus.subkey;
        accepts++;
      end
      cyc++;
      @(negedge clk);
    end
    check("accept_count", 64'(accepts), 64'd16);
    bus.subkey_ready = 1'b0;
    bus.start = inject;
    if (inject) bus.key = ~k;
    check("done_pulse", 64'(bus.done), 64'd1);
    check("done_valid", 64'(bus.subkey_valid), 64'd0);
    check("done_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check("post_done", 64'(bus.done), 64'd0);
    check("post_busy", 64'(bus.busy), 64'd0);
    check("post_valid", 64'(bus.subkey_valid), 64'd0);
    check("post_key_err", 64'(bus.key_err), 64'd0);
  endtask

  task automatic bad_parity(input logic [63:0] k);
    bus.start = 1'b1;
    bus.key   = k;
    bus.decrypt = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("key_err_pulse", 64'(bus.key_err), 64'd1);
    check("key_err_busy", 64'(bus.busy), 64'd0);
    check("key_err_valid", 64'(bus.subkey_valid), 64'd0);
    @(negedge clk);
    check("key_err_clear", 64'(bus.key_err), 64'd0);
    check("key_err_idle", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k;
    logic [47:0] e;
    bit d;

    kat[0] = '{dec: 1'b0, idx: 4'd0,  exp: 48'h1B02EFFC7072};
    kat[1] = '{dec: 1'b0, idx: 4'd1,  exp: 48'h79AED9DBC9E5};
    kat[2] = '{dec: 1'b0, idx: 4'd15, exp: 48'hCB3D8B0E17F5};
    kat[3] = '{dec: 1'b1, idx: 4'd0,  exp: 48'hCB3D8B0E17F5};
    kat[4] = '{dec: 1'b1, idx: 4'd14, exp: 48'h79AED9DBC9E5};
    kat[5] = '{dec: 1'b1, idx: 4'd15, exp: 48'h1B02EFFC7072};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.decrypt = 1'b0;
    bus.key = '0;
    bus.subkey_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_key_err", 64'(bus.key_err), 64'd0);
    check("rst_idx", 64'(bus.round_idx), 64'd0);
    check("rst_subkey", 64'(bus.subkey), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer runs: encrypt and decrypt with ready tied high.
    run_seq(K0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) got_enc[i] = got[i];
    run_seq(K0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) got_dec[i] = got[i];
    for (int i = 0; i < 6; i++) begin
      e = kat[i].dec ? got_dec[kat[i].idx] : got_enc[kat[i].idx];
      check(kat[i].dec ? "kat_dec" : "kat_enc", 64'(e), 64'(kat[i].exp));
    end

    // Backpressure on the reference key, then the KAT again.
    run_seq(K0, 1'b0, 1'b1, 1'b0);
    check("bp_k1", 64'(got[0]), 64'(kat[0].exp));
    check("bp_k16", 64'(got[15]), 64'(kat[2].exp));

    // Parity error followed by a clean start.
    bad_parity(64'h123457799BBCDFF1);
    run_seq(K0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a run at round_idx 7.
    bus.start = 1'b1;
    bus.key = K0;
    bus.decrypt = 1'b0;
    bus.subkey_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_idx", 64'(bus.round_idx), 64'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.subkey_ready = 1'b0;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("mid_rst_idx", 64'(bus.round_idx), 64'd0);
    check("mid_rst_subkey", 64'(bus.subkey), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    check("mid_rst_idle", 64'(bus.subkey_valid), 64'd0);
    run_seq(K0, 1'b0, 1'b0, 1'b0);
    check("after_rst_k1", 64'(got[0]), 64'(kat[0].exp));

    // Start with another key during RUN and DONE is ignored; next IDLE start takes a new key.
    run_seq(K0, 1'b0, 1'b1, 1'b1);
    run_seq(fix_par(64'h0E329232EA6D0D73), 1'b1, 1'b0, 1'b0);

    // Randomized keys, modes and backpressure.
    for (int i = 0; i < 6; i++) begin
      k = fix_par({$urandom, $urandom});
      d = 1'($urandom_range(0, 1));
      run_seq(k, d, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      k = fix_par({$urandom, $urandom}) ^ (64'h1 << $urandom_range(0, 63));
      bad_parity(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
